// File: rtl/alu_pipe.sv
// Pipelined add/subtract/logic ALU with valid/ready flow control and a persistent
// carry register so ADC/SBB can chain multi-word arithmetic.
module alu_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             clr_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero,
   output logic             negative,
   output logic             overflow
);

   typedef enum logic [2:0] {
      OP_ADD   = 3'b000,
      OP_SUB   = 3'b001,
      OP_ADC   = 3'b010,
      OP_SBB   = 3'b011,
      OP_AND   = 3'b100,
      OP_OR    = 3'b101,
      OP_XOR   = 3'b110,
      OP_PASSB = 3'b111
   } op_e;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             c;
      logic             z;
      logic             n;
      logic             v;
   } stage_t;

   logic              creg_q, creg_d;
   logic              accept;
   logic [STAGES-1:0] rdy;
   logic [STAGES-1:0] v_q, v_d;
   stage_t            stg_q [STAGES];
   stage_t            stg_d [STAGES];
   stage_t            stage_in;
   logic [WIDTH-1:0]  bx;
   logic              cin;
   logic [WIDTH:0]    sum;

   // A stage can take new data unless it and every stage after it are full
   // while the consumer stalls; this is the unrolled ready chain.
   for (genvar k = 0; k < STAGES; k++) begin : g_rdy
      assign rdy[k] = out_ready || !(&v_q[STAGES-1:k]);
   end

   assign in_ready = rdy[0];
   assign accept   = in_valid && rdy[0];

   always_comb begin
      bx  = op[0] ? ~b : b;
      cin = op[1] ? (clr_carry ? 1'b0 : creg_q) : op[0];
      sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};

      stage_in = '0;
      case (op_e'(op))
         OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
            stage_in.res = sum[WIDTH-1:0];
            stage_in.c   = sum[WIDTH];
            stage_in.v   = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  stage_in.res = a & b;
         OP_OR:   stage_in.res = a | b;
         OP_XOR:  stage_in.res = a ^ b;
         default: stage_in.res = b;
      endcase
      stage_in.z = (stage_in.res == '0);
      stage_in.n = stage_in.res[WIDTH-1];
   end

   // An arithmetic accept always reloads the carry, even when clr_carry
   // forced its cin to zero; otherwise clr_carry alone clears it.
   always_comb begin
      creg_d = creg_q;
      if (accept && !op[2]) begin
         creg_d = stage_in.c;
      end else if (clr_carry) begin
         creg_d = 1'b0;
      end
   end

   always_comb begin
      v_d   = v_q;
      stg_d = stg_q;
      if (rdy[0]) begin
         v_d[0] = in_valid;
         if (in_valid) begin
            stg_d[0] = stage_in;
         end
      end
      for (int k = 1; k < STAGES; k++) begin
         if (rdy[k]) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) begin
               stg_d[k] = stg_q[k-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q    <= '0;
         creg_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            stg_q[k] <= '0;
         end
      end else begin
         v_q    <= v_d;
         creg_q <= creg_d;
         stg_q  <= stg_d;
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign result    = stg_q[STAGES-1].res;
   assign carry_out = stg_q[STAGES-1].c;
   assign zero      = stg_q[STAGES-1].z;
   assign negative  = stg_q[STAGES-1].n;
   assign overflow  = stg_q[STAGES-1].v;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus randomized traffic
// checked against an integer-arithmetic reference model and an in-order scoreboard.
module tb_alu_pipe;

   localparam int W      = 8;
   localparam int STAGES = 2;
   localparam int MAXU   = (1 << W) - 1;
   localparam int MAXS   = (1 << (W - 1)) - 1;
   localparam int MINS   = -(1 << (W - 1));

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   op;
   logic         clr_carry;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry_out;
   logic         zero;
   logic         negative;
   logic         overflow;

   int           total = 0;
   int           bad = 0;
   int           outCount = 0;
   logic [W+3:0] expQ[$];
   logic [W+3:0] monE;
   logic         modelCarry = 1'b0;
   bit           randDone;
   int           cnt0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(W), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .clr_carry (clr_carry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .zero      (zero),
      .negative  (negative),
      .overflow  (overflow)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain signed/unsigned integer arithmetic; returns {res, c, z, n, v}.
   function automatic logic [W+3:0] refOp(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic clr, input logic cr);
      int ua, ub, sa, sb, full, sfull, ci, bw;
      logic [W-1:0] r;
      logic c, v;
      ua = int'(x);
      ub = int'(y);
      sa = x[W-1] ? ua - (1 << W) : ua;
      sb = y[W-1] ? ub - (1 << W) : ub;
      ci = clr ? 0 : int'(cr);
      full = 0;
      sfull = 0;
      c = 1'b0;
      case (o)
         3'd0: begin full = ua + ub; sfull = sa + sb; c = (full > MAXU); end
         3'd1: begin full = ua - ub; sfull = sa - sb; c = (ua >= ub); end
         3'd2: begin full = ua + ub + ci; sfull = sa + sb + ci; c = (full > MAXU); end
         3'd3: begin bw = 1 - ci; full = ua - ub - bw; sfull = sa - sb - bw; c = (ua >= ub + bw); end
         3'd4: full = ua & ub;
         3'd5: full = ua | ub;
         3'd6: full = ua ^ ub;
         default: full = ub;
      endcase
      r = full[W-1:0];
      v = (o < 3'd4) && ((sfull > MAXS) || (sfull < MINS));
      return {r, c, (r == '0), r[W-1], v};
   endfunction

   // Scoreboard: check the head while out_valid, pop on transfer, push on accept.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               checkOutput("scoreboard", 32'({result, carry_out, zero, negative, overflow}), 32'(expQ[0]));
               if (out_ready) begin
                  monE = expQ.pop_front();
                  outCount++;
               end
            end
         end
         if (in_valid && in_ready) begin
            monE = refOp(op, a, b, clr_carry, modelCarry);
            expQ.push_back(monE);
            if (!op[2]) modelCarry = monE[3];
            else if (clr_carry) modelCarry = 1'b0;
         end else if (clr_carry) begin
            modelCarry = 1'b0;
         end
      end
   end

   task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic clr);
      int n = 0;
      logic acc;
      in_valid  = 1'b1;
      op        = o;
      a         = x;
      b         = y;
      clr_carry = clr;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 100);
      if (!acc) checkOutput("accept_timeout", 32'(acc), 32'd1);
      in_valid  = 1'b0;
      clr_carry = 1'b0;
      op        = 3'($urandom_range(0, 7));
      a         = W'($urandom);
      b         = W'($urandom);
   endtask

   task automatic directed(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic clr, input logic [W+3:0] want);
      int n = 0;
      out_ready = 1'b1;
      applyStimulus(o, x, y, clr);
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 50);
      checkOutput({tag, "_lat"}, 32'(n), 32'(STAGES));
      checkOutput(tag, 32'({result, carry_out, zero, negative, overflow}), 32'(want));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (STAGES + 3) @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog got=running exp=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = 3'd0;
      a         = '0;
      b         = '0;
      clr_carry = 1'b0;
      out_ready = 1'b1;
      #12;
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_outputs", 32'({result, carry_out, zero, negative, overflow}), 32'd0);
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

      directed("add_wrap", 3'd0, 8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
      directed("sub_ovf",  3'd1, 8'h80, 8'h01, 1'b0, {8'h7F, 1'b1, 1'b0, 1'b0, 1'b1});
      directed("sub_borrow", 3'd1, 8'h05, 8'h07, 1'b0, {8'hFE, 1'b0, 1'b0, 1'b1, 1'b0});
      directed("add_set", 3'd0, 8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
      directed("adc_carry", 3'd2, 8'h00, 8'h00, 1'b0, {8'h01, 1'b0, 1'b0, 1'b0, 1'b0});
      directed("add_set2", 3'd0, 8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
      directed("adc_clr", 3'd2, 8'h00, 8'h00, 1'b1, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
      directed("sbb_borrow", 3'd3, 8'h05, 8'h03, 1'b0, {8'h01, 1'b1, 1'b0, 1'b0, 1'b0});
      directed("sbb_noborrow", 3'd3, 8'h05, 8'h05, 1'b0, {8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
      directed("add_set3", 3'd0, 8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
      directed("and_op", 3'd4, 8'hF0, 8'h3C, 1'b0, {8'h30, 1'b0, 1'b0, 1'b0, 1'b0});
      directed("xor_zero", 3'd6, 8'hA5, 8'hA5, 1'b0, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
      directed("adc_kept", 3'd2, 8'h00, 8'h00, 1'b0, {8'h01, 1'b0, 1'b0, 1'b0, 1'b0});
      directed("passb", 3'd7, 8'h12, 8'h9C, 1'b0, {8'h9C, 1'b0, 1'b0, 1'b1, 1'b0});

      // Back-pressure: fill the pipe, hold a pending op, then release.
      drain();
      out_ready = 1'b0;
      for (int i = 0; i < STAGES; i++) applyStimulus(3'd0, W'($urandom), W'($urandom), 1'b0);
      in_valid = 1'b1;
      op       = 3'd0;
      a        = 8'h11;
      b        = 8'h22;
      repeat (6) begin
         @(negedge clk);
         checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
         checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      cnt0 = outCount;
      out_ready = 1'b1;
      applyStimulus(3'd0, 8'h11, 8'h22, 1'b0);
      applyStimulus(3'd0, 8'h7F, 8'h01, 1'b0);
      drain();
      checkOutput("stall_out_count", 32'(outCount - cnt0), 32'(STAGES + 2));

      // Asynchronous reset with operations in flight.
      out_ready = 1'b0;
      applyStimulus(3'd0, 8'hFF, 8'h01, 1'b0);
      if (STAGES > 1) applyStimulus(3'd0, 8'h10, 8'h20, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("async_rst_outputs", 32'({result, carry_out, zero, negative, overflow}), 32'd0);
      expQ.delete();
      modelCarry = 1'b0;
      #10 rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
      repeat (4) begin
         @(negedge clk);
         checkOutput("post_rst_idle", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      directed("adc_after_rst", 3'd2, 8'h00, 8'h00, 1'b0, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});

      // Randomized traffic with random consumer back-pressure.
      randDone = 1'b0;
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  clr_carry = 1'($urandom_range(0, 1));
                  @(posedge clk);
                  #1;
                  clr_carry = 1'b0;
               end
               applyStimulus(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
                             ($urandom_range(0, 5) == 0));
            end
            randDone = 1'b1;
         end
         begin
            while (!randDone) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
         end
      join
      drain();
      checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
